// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared types and constants for the instruction fetch unit.
//   Holds the fetch FSM state encoding, the default reset PC and the instruction width.
package ifu_fetch_pkg;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] DEF_RESET_PC = 32'h8000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_t;
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundles the imem request/response, redirect and decode-side signals.
//   master: the fetch unit (drives imem requests and decode outputs).
//   slave : the environment (memory, execute redirect, decode).
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_fault;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifu_fetch_fifo.sv
// ifu_fifo: synchronous FIFO with push/pop/flush and an occupancy count.
//   clk, rst (async active-low), push/din, pop, flush (wins over push/pop),
//   dout (registered head entry), count (entries held, 0..DEPTH).
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd = pop && (count != '0);
  assign wr = push && ((count != CW'(DEPTH)) || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding decode.
//   Ports: clk, rst (async active-low), bus (ifu_fetch_if.master: imem request
//   valid/ready/addr, imem response valid/data/err, redirect valid/pc,
//   decode inst_valid/inst_ready/inst/pc, sticky fetch_fault).
//   Build option IFU_ALIGN_CHECK_EN: a misaligned redirect target faults and halts
//   fetch; without it the low two target bits are cleared.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEP = CW'(FIFO_DEPTH);
  state_t state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx, req_addr, rdr_pc, rsp_d;
  logic rsp_v, rsp_e, fault, fault_nx;
  logic hs, rdr, bad_align, busy, push, pop, free, room;
  logic [CW-1:0] count;
  logic [2*ILEN-1:0] head;
  assign rdr = bus.redirect_valid && (state != HALT);
`ifdef IFU_ALIGN_CHECK_EN
  assign rdr_pc = bus.redirect_pc;
  assign bad_align = rdr && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign rdr_pc = bus.redirect_pc & 32'hffff_fffc;
  assign bad_align = 1'b0;
`endif
  assign hs = (state == REQ) && bus.imem_req_ready;
  // Response is registered first, so nothing from imem_rsp reaches inst_valid combinationally.
  assign busy = hs || (((state == WAIT) || (state == DROP)) && !rsp_v);
  assign push = (state == WAIT) && rsp_v && !rsp_e && !rdr;
  assign pop = bus.inst_valid && bus.inst_ready;
  assign free = count < DEP;
  assign room = (count + CW'(!pop)) < DEP;
  always_comb begin
    state_nx = state;
    fault_nx = fault;
    fetch_pc_nx = hs ? fetch_pc + 32'd4 : fetch_pc;
    if (rdr) begin
      fetch_pc_nx = rdr_pc;
      fault_nx = fault | bad_align;
      state_nx = busy ? DROP : (fault_nx ? HALT : REQ);
    end else begin
      case (state)
        IDLE: state_nx = free ? REQ : IDLE;
        REQ:  state_nx = hs ? WAIT : REQ;
        WAIT: begin
          state_nx = !rsp_v ? WAIT : rsp_e ? HALT : room ? REQ : IDLE;
          fault_nx = fault | (rsp_v && rsp_e);
        end
        DROP: state_nx = !rsp_v ? DROP : fault ? HALT : REQ;
        default: state_nx = HALT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      fault <= 1'b0;
      rsp_v <= 1'b0;
      rsp_e <= 1'b0;
      rsp_d <= '0;
    end else begin
      state <= state_nx;
      fetch_pc <= fetch_pc_nx;
      fault <= fault_nx;
      rsp_v <= bus.imem_rsp_valid;
      rsp_e <= bus.imem_rsp_err;
      rsp_d <= bus.imem_rsp_data;
      if (hs) req_addr <= fetch_pc;
    end
  ifu_fifo #(.WIDTH(2 * ILEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({req_addr, rsp_d}),
    .pop(pop),
    .flush(rdr),
    .dout(head),
    .count(count)
  );
  assign bus.imem_req_valid = state == REQ;
  assign bus.imem_req_addr = fetch_pc;
  assign bus.inst_valid = count != '0;
  assign bus.pc = head[2*ILEN-1:ILEN];
  assign bus.inst = head[ILEN-1:0];
  assign bus.fetch_fault = fault;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch with a one-cycle memory model.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ifu_fetch_if bus();
  ifu_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rsp_cyc = -1;
  int iv_cyc = -1;
  logic [31:0] err_addr = '1;
  logic [31:0] req_log[$];
  logic [63:0] pop_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] req_at(input int i);
    return (i < req_log.size()) ? 64'(req_log[i]) : '1;
  endfunction

  function automatic logic [63:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : '1;
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) req_log.push_back(bus.imem_req_addr);
      if (bus.inst_valid && bus.inst_ready) pop_log.push_back({bus.pc, bus.inst});
      if (bus.imem_rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
      if (bus.inst_valid && iv_cyc < 0) iv_cyc = cyc;
      cyc++;
    end
  end

  initial begin : memory
    logic [31:0] a;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.imem_rsp_err = 1'b0;
    forever begin
      @(posedge clk);
      if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
        a = bus.imem_req_addr;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'h0010_0093 + (a - 32'h8000_0000);
        bus.imem_rsp_err = (a == err_addr);
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err = 1'b0;
      end
    end
  end

  task automatic reset_dut();
    bus.imem_req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst_pc", {bus.pc, bus.inst}, 64'd0);
    check("rst_fault", 64'(bus.fetch_fault), 64'd0);
    req_log.delete();
    pop_log.delete();
    rsp_cyc = -1;
    iv_cyc = -1;
    err_addr = '1;
    rst = 1'b1;
  endtask

  initial begin
    reset_dut();
    // first fetch, then backpressure fills the FIFO
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    check("t1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("t1_req_addr", 64'(bus.imem_req_addr), 64'h8000_0000);
    repeat (20) @(negedge clk);
    check("t1_inst_valid", 64'(bus.inst_valid), 64'd1);
    check("t1_head", {bus.pc, bus.inst}, {32'h8000_0000, 32'h0010_0093});
    check("t1_latency", 64'(rsp_cyc >= 0 && iv_cyc - rsp_cyc >= 2), 64'd1);
    check("t2_req_count", 64'(req_log.size()), 64'd2);
    check("t2_req1", req_at(1), 64'h8000_0004);
    check("t2_stalled", 64'(bus.imem_req_valid), 64'd0);
    bus.inst_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_pop0", pop_at(0), {32'h8000_0000, 32'h0010_0093});
    check("t2_pop1", pop_at(1), {32'h8000_0004, 32'h0010_0097});
    check("t2_pop2", pop_at(2), {32'h8000_0008, 32'h0010_009b});
    check("t2_resume", req_at(2), 64'h8000_0008);
    // redirect while the second request is outstanding
    reset_dut();
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 50 && req_log.size() < 2; i++) @(negedge clk);
    check("t3_two_req", 64'(req_log.size()), 64'd2);
    check("t3_pre_valid", 64'(bus.inst_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b1;
    check("t3_flushed", 64'(bus.inst_valid), 64'd0);
    repeat (15) @(negedge clk);
    check("t3_req2", req_at(2), 64'h8000_0100);
    check("t3_pop0", pop_at(0), {32'h8000_0100, 32'h0010_0193});
    // retarget of an unaccepted request
    reset_dut();
    bus.inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_hold_valid", 64'(bus.imem_req_valid), 64'd1);
    check("t4_hold_addr", 64'(bus.imem_req_addr), 64'h8000_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t4_retarget", 64'(bus.imem_req_addr), 64'h8000_0200);
    check("t4_still_valid", 64'(bus.imem_req_valid), 64'd1);
    repeat (2) @(negedge clk);
    check("t4_none_acc", 64'(req_log.size()), 64'd0);
    bus.imem_req_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_req0", req_at(0), 64'h8000_0200);
    check("t4_req1", req_at(1), 64'h8000_0204);
    check("t4_pop0", pop_at(0), {32'h8000_0200, 32'h0010_0293});
    check("t4_pop1", pop_at(1), {32'h8000_0204, 32'h0010_0297});
    // bus error on the third fetch
    reset_dut();
    err_addr = 32'h8000_0008;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_fault", 64'(bus.fetch_fault), 64'd1);
    check("t5_req_count", 64'(req_log.size()), 64'd3);
    check("t5_no_req", 64'(bus.imem_req_valid), 64'd0);
    check("t5_pop_count", 64'(pop_log.size()), 64'd2);
    check("t5_pop0", pop_at(0), {32'h8000_0000, 32'h0010_0093});
    check("t5_pop1", pop_at(1), {32'h8000_0004, 32'h0010_0097});
    // misaligned redirect target
    reset_dut();
    repeat (3) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0102;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
`ifdef IFU_ALIGN_CHECK_EN
    check("t6_fault", 64'(bus.fetch_fault), 64'd1);
    check("t6_no_req", 64'(req_log.size()), 64'd0);
`else
    check("t6_fault", 64'(bus.fetch_fault), 64'd0);
    check("t6_req0", req_at(0), 64'h8000_0100);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the decode stage.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request channel with a valid-only response.
- Buffers returned {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect (dnpc from execute) that flushes in-flight and buffered work.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded at reset.
- FIFO_DEPTH, 2, number of buffered {pc, inst} entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid, exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid.
- redirect_valid  in  1  one-cycle pulse: next PC is redirect_pc.
- redirect_pc  in  32  redirect target (dnpc).
- inst_valid  out  1  decode-side entry valid.
- inst_ready  in  1  decode consumes entry.
- inst  out  32  instruction to decode.
- pc  out  32  PC of inst.
- fetch_fault  out  1  sticky; fetch halted on error.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty.
  - inst_valid=0, imem_req_valid=0, inst=0, pc=0, fetch_fault=0.
  - State IDLE.
- At most one outstanding request.
- FSM states: IDLE, REQ, WAIT, DROP, HALT.
- IDLE: if no redirect and FIFO has a free slot (count<FIFO_DEPTH), go to REQ next cycle.
- REQ: imem_req_valid=1, addr=fetch_pc.
  - Handshake (valid&ready): go to WAIT, fetch_pc+=4 (wraps mod 2^32).
  - addr stays stable while not accepted.
- WAIT: on rsp_valid, push {addr_of_req, data}; go to REQ if a slot remains after push, else IDLE.
- rsp_err in WAIT: no push, fetch_fault=1, go to HALT.
- HALT: no requests until reset; FIFO still drains.
- Redirect, any state except HALT, in the cycle it is seen:
  - FIFO flushed (count=0, inst_valid=0 next cycle).
  - fetch_pc=redirect_pc.
  - If a request is accepted-but-unanswered (WAIT), or accepted in that same cycle, go to DROP.
  - Otherwise go to REQ.
  - A request in REQ not yet accepted is retargeted: imem_req_addr=redirect_pc from next cycle.
- DROP: the next rsp_valid is discarded, errors included; then go to REQ.
- Redirect in DROP: update fetch_pc, stay in DROP.
- Redirect wins over push and pop in the same cycle: the popped entry is treated as consumed, the pushed entry is discarded.
- FIFO:
  - Push and pop in the same cycle when full is allowed; count unchanged.
  - inst/pc are the head entry, registered; no combinational path from imem_rsp to inst_valid.
  - Fetch-to-decode latency: first inst_valid at least 2 cycles after the response.
- Free-slot check includes the outstanding request: REQ is entered only if count + outstanding < FIFO_DEPTH.

Optional Feature:
- Macro IFU_ALIGN_CHECK_EN.
- Defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault, flushes FIFO, goes to HALT (via DROP first if a response is outstanding), and issues no request.
- Undefined: redirect_pc[1:0] is forced to 0 and fetch proceeds normally.

Decomposition:
- Shared package: FSM state encoding (IDLE, REQ, WAIT, DROP, HALT), RESET_PC default, instruction width 32.
- Sub-module ifu_fifo: synchronous FIFO with push/pop/flush, count output, async active-low reset; instantiated once with 64-bit {pc, inst} entries.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response 32'h00100093 -> first request addr 32'h8000_0000; inst_valid with inst=32'h00100093, pc=32'h8000_0000.
- inst_ready=0, memory always ready -> exactly FIFO_DEPTH fetches (0x80000000, 0x80000004), then imem_req_valid stays 0; raising inst_ready drains in order and fetch resumes at 0x80000008.
- Redirect to 32'h8000_0100 while in WAIT -> the pending response is dropped and not presented; next request addr 32'h8000_0100; FIFO empty the cycle after redirect.
- imem_req_ready held 0 for 5 cycles, redirect mid-wait -> addr switches to the redirect target; no request is lost or duplicated.
- rsp_err=1 on the third fetch -> fetch_fault=1; no further requests; the two earlier entries are still delivered.
- With IFU_ALIGN_CHECK_EN, redirect_pc=32'h8000_0102 -> fetch_fault=1, no request issued; without the macro -> request at 32'h8000_0100.
